yacc_cache_ctrl: RTL and testbench

// - Synthesizable, parametrised YACC compressed cache controller with LRU replacement.
// - Sits between a request port (lower-level cache side) and a line-fill memory port.
// - Each way holds one superblock. A superblock covers 4 consecutive blocks that share one tag.
// - Hits return uncompressed data. Misses fetch the line, classify its compression factor (CF), then install or merge it.

---
 rtl/yacc_pkg.sv | 54 +++++
 rtl/yacc_lru_stack.sv | 61 ++++++
 rtl/yacc_cache_ctrl.sv | 279 +++++++++++++++++++++++++++
 tb/tb_yacc_cache_ctrl.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/yacc_pkg.sv
// yacc_pkg: shared types and constants for the YACC compressed cache controller.
//   cf_e        : compression factor of a stored superblock (none, /2, /4)
//   state_e     : controller FSM states
//   tag_entry_t : per-way tag entry (valid, tag, cf, id0, id1, qmask)
//   entry_hits  : decides whether a tag entry holds a given block of a given tag
package yacc_pkg;

    localparam int OFF_W     = 6;
    localparam int BLK_W     = 2;
    // Tags are held at a fixed maximum width so the struct does not depend on
    // the address/set parameters; narrower tags are zero-extended on store.
    localparam int TAG_MAX_W = 32;

    typedef enum logic [1:0] {
        CF_NONE  = 2'b00,
        CF_HALF  = 2'b01,
        CF_QUART = 2'b10
    } cf_e;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_REQ,
        MISS_WAIT,
        FILL,
        RESP
    } state_e;

    // qmask[0] marks id0 present, qmask[1] marks id1 present for /2 lines;
    // for /4 lines qmask[q] marks block q present.
    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        cf_e                  cf;
        logic [BLK_W-1:0]     id0;
        logic [BLK_W-1:0]     id1;
        logic [3:0]           qmask;
    } tag_entry_t;

    // A way hits when it is valid, the tag matches, and the block is one of
    // the blocks its compression layout currently holds.
    function automatic logic entry_hits(tag_entry_t e, logic [TAG_MAX_W-1:0] tag,
                                        logic [BLK_W-1:0] blk);
        logic id_ok;
        case (e.cf)
            CF_NONE:  id_ok = (e.id0 == blk);
            CF_HALF:  id_ok = (e.id0 == blk) || ((e.id1 == blk) && e.qmask[1]);
            CF_QUART: id_ok = e.qmask[blk];
            default:  id_ok = 1'b0;
        endcase
        return e.valid && (e.tag == tag) && id_ok;
    endfunction

endpackage

// File: rtl/yacc_lru_stack.sv
// yacc_lru_stack: per-set recency stack. Position 0 is MRU, position WAYS-1
// is the replacement victim. Reset order is {0, 1, ..., WAYS-1}.
// Ports:
//   clock, reset_n           : clock, asynchronous active-low reset
//   touch_en/set/way         : move 'way' of 'set' to MRU this cycle
//   victim_set / victim_way  : LRU way of the queried set
module yacc_lru_stack #(
    parameter int SETS = 8,
    parameter int WAYS = 8
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    touch_en,
    input  logic [$clog2(SETS)-1:0] touch_set,
    input  logic [$clog2(WAYS)-1:0] touch_way,
    input  logic [$clog2(SETS)-1:0] victim_set,
    output logic [$clog2(WAYS)-1:0] victim_way
);

    localparam int WW = $clog2(WAYS);

    logic [WW-1:0] stack_q     [SETS][WAYS];
    logic [WW-1:0] touched_row [WAYS];
    logic          seen;

    // Build the touched set's new order: the touched way goes to position 0,
    // entries above its old position shift down one place, entries below stay.
    always_comb begin
        seen = 1'b0;
        for (int i = 0; i < WAYS; i++) begin
            touched_row[i] = stack_q[touch_set][i];
        end
        touched_row[0] = touch_way;
        for (int i = 1; i < WAYS; i++) begin
            if (stack_q[touch_set][i-1] == touch_way) begin
                seen = 1'b1;
            end
            if (!seen) begin
                touched_row[i] = stack_q[touch_set][i-1];
            end
        end
    end

    // Stack storage; reset puts way i at position i in every set.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SETS; s++) begin
                for (int i = 0; i < WAYS; i++) begin
                    stack_q[s][i] <= WW'(i);
                end
            end
        end else if (touch_en) begin
            for (int i = 0; i < WAYS; i++) begin
                stack_q[touch_set][i] <= touched_row[i];
            end
        end
    end

    assign victim_way = stack_q[victim_set][WAYS-1];

endmodule

// File: rtl/yacc_cache_ctrl.sv
// yacc_cache_ctrl: YACC compressed cache controller with LRU replacement.
// Each way holds one superblock (4 consecutive blocks sharing a tag). Fill
// lines are classified as uncompressed, /2 or /4 and either merged into a
// compatible way or installed over a victim.
// Ports:
//   clock, reset_n                  : clock, asynchronous active-low reset
//   req_valid/ready/addr            : request port (ready only in IDLE)
//   resp_valid/hit/data             : one-cycle response pulse, uncompressed line
//   mem_req_valid/ready/addr        : line-fill request (line-aligned address)
//   mem_rsp_valid/data              : fill data, taken only in MISS_WAIT
//   hit_cnt, miss_cnt               : saturating response counters
// Build option: define YACC_STATS_EN to build the counters; otherwise both
// counter outputs are tied to zero.
module yacc_cache_ctrl
    import yacc_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 512,
    parameter int SETS   = 8,
    parameter int WAYS   = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic [LINE_W-1:0] resp_data,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [LINE_W-1:0] mem_rsp_data,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
);

    localparam int IW      = $clog2(SETS);
    localparam int WW      = $clog2(WAYS);
    localparam int TAG_LSB = OFF_W + BLK_W + IW;
    localparam int Q_W     = LINE_W / 4;
    localparam int H_W     = LINE_W / 2;

    state_e                 state_q, state_d;
    logic [ADDR_W-1:OFF_W]  addr_q;
    logic [LINE_W-1:0]      fill_q;
    logic [LINE_W-1:0]      resp_data_q;
    logic                   resp_hit_q;
    tag_entry_t             tags_q [SETS][WAYS];
    logic [LINE_W-1:0]      data_q [SETS][WAYS];

    logic [BLK_W-1:0]       blk;
    logic [IW-1:0]          set;
    logic [TAG_MAX_W-1:0]   tag_ext;

    logic                   hit_any;
    logic [WW-1:0]          hit_way;
    tag_entry_t             hit_entry;
    logic [LINE_W-1:0]      hit_line;
    logic [LINE_W-1:0]      hit_data;

    cf_e                    fill_cf;
    logic                   merge_found, inv_found;
    logic [WW-1:0]          merge_way, inv_way, lru_way, wr_way;
    tag_entry_t             wr_entry;
    logic [LINE_W-1:0]      wr_line;

    logic                   touch_en;
    logic [WW-1:0]          touch_way;

    // The byte offset never affects line-granular behaviour.
    logic                   unused_offset;
    assign unused_offset = ^req_addr[OFF_W-1:0];

    assign blk     = addr_q[OFF_W+BLK_W-1:OFF_W];
    assign set     = addr_q[TAG_LSB-1:OFF_W+BLK_W];
    assign tag_ext = TAG_MAX_W'(addr_q[ADDR_W-1:TAG_LSB]);

    // Tag lookup: scan from the top so the lowest hitting way index wins,
    // then unpack the requested block from that way's compressed layout.
    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (entry_hits(tags_q[set][w], tag_ext, blk)) begin
                hit_any = 1'b1;
                hit_way = WW'(w);
            end
        end
        hit_entry = tags_q[set][hit_way];
        hit_line  = data_q[set][hit_way];
        case (hit_entry.cf)
            CF_HALF:  hit_data = (hit_entry.id0 == blk) ? LINE_W'(hit_line[H_W-1:0])
                                                         : LINE_W'(hit_line[LINE_W-1:H_W]);
            CF_QUART: hit_data = LINE_W'(hit_line[int'(blk)*Q_W +: Q_W]);
            default:  hit_data = hit_line;
        endcase
    end

    // Fill placement: classify the line, look for a merge target with a free
    // slot, otherwise pick the lowest invalid way or the LRU victim, and build
    // the tag entry and data image to write.
    always_comb begin
        if (fill_q[LINE_W-1:Q_W] == '0) begin
            fill_cf = CF_QUART;
        end else if (fill_q[LINE_W-1:H_W] == '0) begin
            fill_cf = CF_HALF;
        end else begin
            fill_cf = CF_NONE;
        end

        merge_found = 1'b0;
        merge_way   = '0;
        inv_found   = 1'b0;
        inv_way     = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (tags_q[set][w].valid && (tags_q[set][w].tag == tag_ext) &&
                (tags_q[set][w].cf == fill_cf) &&
                (((fill_cf == CF_HALF)  && !tags_q[set][w].qmask[1]) ||
                 ((fill_cf == CF_QUART) && !tags_q[set][w].qmask[blk]))) begin
                merge_found = 1'b1;
                merge_way   = WW'(w);
            end
            if (!tags_q[set][w].valid) begin
                inv_found = 1'b1;
                inv_way   = WW'(w);
            end
        end

        if (merge_found) begin
            wr_way = merge_way;
        end else if (inv_found) begin
            wr_way = inv_way;
        end else begin
            wr_way = lru_way;
        end

        wr_entry = tags_q[set][wr_way];
        wr_line  = data_q[set][wr_way];
        if (merge_found) begin
            if (fill_cf == CF_HALF) begin
                wr_entry.id1            = blk;
                wr_entry.qmask[1]       = 1'b1;
                wr_line[LINE_W-1:H_W]   = fill_q[H_W-1:0];
            end else begin
                wr_entry.qmask[blk]     = 1'b1;
                wr_line[int'(blk)*Q_W +: Q_W] = fill_q[Q_W-1:0];
            end
        end else begin
            wr_entry.valid = 1'b1;
            wr_entry.tag   = tag_ext;
            wr_entry.cf    = fill_cf;
            wr_entry.id0   = blk;
            wr_entry.id1   = '0;
            if (fill_cf == CF_QUART) begin
                wr_entry.qmask = 4'b0001 << blk;
                wr_line        = '0;
                wr_line[int'(blk)*Q_W +: Q_W] = fill_q[Q_W-1:0];
            end else begin
                wr_entry.qmask = 4'b0001;
                wr_line        = fill_q;
            end
        end
    end

    // Next-state logic, recency updates and port handshakes.
    always_comb begin
        state_d       = state_q;
        touch_en      = 1'b0;
        touch_way     = hit_way;
        req_ready     = (state_q == IDLE);
        mem_req_valid = (state_q == MISS_REQ);
        resp_valid    = (state_q == RESP);
        case (state_q)
            IDLE:      if (req_valid) state_d = LOOKUP;
            LOOKUP: begin
                if (hit_any) begin
                    state_d  = RESP;
                    touch_en = 1'b1;
                end else begin
                    state_d  = MISS_REQ;
                end
            end
            MISS_REQ:  if (mem_req_ready) state_d = MISS_WAIT;
            MISS_WAIT: if (mem_rsp_valid) state_d = FILL;
            FILL: begin
                state_d   = RESP;
                touch_en  = 1'b1;
                touch_way = wr_way;
            end
            RESP:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    assign resp_hit     = resp_valid && resp_hit_q;
    assign resp_data    = resp_data_q;
    assign mem_req_addr = {addr_q, {OFF_W{1'b0}}};

    // Control state, captured request/fill and the tag array.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            fill_q      <= '0;
            resp_data_q <= '0;
            resp_hit_q  <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    tags_q[s][w] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE) && req_valid) begin
                addr_q <= req_addr[ADDR_W-1:OFF_W];
            end
            if ((state_q == MISS_WAIT) && mem_rsp_valid) begin
                fill_q <= mem_rsp_data;
            end
            if ((state_q == LOOKUP) && hit_any) begin
                resp_hit_q  <= 1'b1;
                resp_data_q <= hit_data;
            end
            if (state_q == FILL) begin
                resp_hit_q            <= 1'b0;
                resp_data_q           <= fill_q;
                tags_q[set][wr_way]   <= wr_entry;
            end
        end
    end

    // Line data storage; contents are only meaningful where a tag entry says
    // so, so it needs no reset.
    always_ff @(posedge clock) begin
        if (state_q == FILL) begin
            data_q[set][wr_way] <= wr_line;
        end
    end

    yacc_lru_stack #(
        .SETS (SETS),
        .WAYS (WAYS)
    ) u_lru (
        .clock      (clock),
        .reset_n    (reset_n),
        .touch_en   (touch_en),
        .touch_set  (set),
        .touch_way  (touch_way),
        .victim_set (set),
        .victim_way (lru_way)
    );

`ifdef YACC_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    // Saturating response counters, split by hit/miss.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == RESP) begin
            if (resp_hit_q) begin
                if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
            end else begin
                if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_yacc_cache_ctrl.sv
// tb_yacc_cache_ctrl: scoreboard bench for yacc_cache_ctrl. A reference model
// of superblocks (blocks present per way, recency timestamps) predicts every
// response; expected responses and fill traffic are queued at issue time and
// checked by independent monitor and memory-responder processes.
`timescale 1ns/1ps
module tb_yacc_cache_ctrl;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 512;
    localparam int SETS   = 8;
    localparam int WAYS   = 8;
    localparam int Q_W    = LINE_W / 4;
    localparam int H_W    = LINE_W / 2;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              resp_valid;
    logic              resp_hit;
    logic [LINE_W-1:0] resp_data;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_rsp_valid;
    logic [LINE_W-1:0] mem_rsp_data;
    logic [31:0]       hit_cnt;
    logic [31:0]       miss_cnt;

    always #5 clock = ~clock;

    yacc_cache_ctrl #(
        .ADDR_W (ADDR_W), .LINE_W (LINE_W), .SETS (SETS), .WAYS (WAYS)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .resp_valid    (resp_valid),
        .resp_hit      (resp_hit),
        .resp_data     (resp_data),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .hit_cnt       (hit_cnt),
        .miss_cnt      (miss_cnt)
    );

    typedef struct packed {
        logic              hit;
        logic [LINE_W-1:0] data;
    } exp_t;

    int checks   = 0;
    int failures = 0;

    exp_t              expQ[$];
    logic [ADDR_W-1:0] memAddrQ[$];
    logic [LINE_W-1:0] memDataQ[$];

    int   readyDelay = 0;
    int   rspDelay   = 0;
    int   respMode   = 0;
    logic mAccepted  = 1'b0;
    logic lateGo     = 1'b0;

    // Reference model: what each way holds as a set of blocks, plus a
    // recency timestamp per way (largest = most recent).
    logic              mValid [SETS][WAYS];
    logic [20:0]       mTag   [SETS][WAYS];
    int                mCf    [SETS][WAYS];
    logic [3:0]        mHas   [SETS][WAYS];
    logic [LINE_W-1:0] mData  [SETS][WAYS][4];
    longint            mStamp [SETS][WAYS];
    longint            tick;
    int                modelHits, modelMisses;

    task automatic checkOutput(input string name, input logic [LINE_W-1:0] act,
                               input logic [LINE_W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s: DUT event did not arrive within its cycle budget", name);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    function automatic void modelReset();
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                mValid[s][w] = 1'b0;
                mHas[s][w]   = 4'b0;
                mStamp[s][w] = -longint'(w);
            end
        end
        tick        = 0;
        modelHits   = 0;
        modelMisses = 0;
    endfunction

    function automatic int modelCf(input logic [LINE_W-1:0] line);
        if ((line >> Q_W) == '0) return 2;
        if ((line >> H_W) == '0) return 1;
        return 0;
    endfunction

    // kind 0: uncompressed, 1: upper half zero, 2: upper three quarters zero
    function automatic logic [LINE_W-1:0] genLine(input int kind);
        logic [LINE_W-1:0] l;
        l = '0;
        for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
        if (kind == 0) begin
            l[LINE_W-1] = 1'b1;
        end else if (kind == 1) begin
            l = (l << H_W) >> H_W;
            l[H_W-1] = 1'b1;
        end else begin
            l = (l << (LINE_W - Q_W)) >> (LINE_W - Q_W);
        end
        return l;
    endfunction

    // Predict the outcome of one request, queue the expectations, drive the
    // request and wait for its response.
    task automatic applyStimulus(input logic [ADDR_W-1:0] addr,
                                 input logic [LINE_W-1:0] line, input int rdyDelay);
        int          s, blk, hitWay, way, cf, n;
        logic [20:0] tag;
        exp_t        e;
        logic        seen;
        s      = int'(addr[10:8]);
        blk    = int'(addr[7:6]);
        tag    = addr[31:11];
        hitWay = -1;
        for (int w = 0; w < WAYS; w++) begin
            if (hitWay < 0 && mValid[s][w] && mTag[s][w] == tag && mHas[s][w][blk]) hitWay = w;
        end
        if (hitWay >= 0) begin
            way    = hitWay;
            e.hit  = 1'b1;
            e.data = mData[s][way][blk];
            modelHits++;
        end else begin
            cf  = modelCf(line);
            way = -1;
            for (int w = 0; w < WAYS; w++) begin
                if (way < 0 && cf != 0 && mValid[s][w] && mTag[s][w] == tag && mCf[s][w] == cf &&
                    ((cf == 2) ? !mHas[s][w][blk] : ($countones(mHas[s][w]) == 1))) way = w;
            end
            if (way >= 0) begin
                mHas[s][way][blk] = 1'b1;
            end else begin
                for (int w = 0; w < WAYS; w++) if (way < 0 && !mValid[s][w]) way = w;
                if (way < 0) begin
                    way = 0;
                    for (int w = 1; w < WAYS; w++) if (mStamp[s][w] < mStamp[s][way]) way = w;
                end
                mValid[s][way] = 1'b1;
                mTag[s][way]   = tag;
                mCf[s][way]    = cf;
                mHas[s][way]   = 4'b0001 << blk;
            end
            mData[s][way][blk] = line;
            e.hit  = 1'b0;
            e.data = line;
            memAddrQ.push_back({addr[31:6], 6'b0});
            memDataQ.push_back(line);
            modelMisses++;
        end
        tick++;
        mStamp[s][way] = tick;
        expQ.push_back(e);

        readyDelay = rdyDelay;
        rspDelay   = $urandom_range(0, 3);
        n = 0;
        while (req_ready !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (req_ready !== 1'b1) timeoutFail("req_ready_wait");
        req_addr  = addr;
        req_valid = 1'b1;
        @(posedge clock);
        #1 req_valid = 1'b0;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 300) begin
            @(negedge clock);
            n++;
            if (resp_valid === 1'b1) seen = 1'b1;
        end
        if (!seen) timeoutFail("resp_wait");
        if (e.hit) checkOutput("hit_latency", LINE_W'(n), LINE_W'(2));
    endtask

    task automatic resetDut();
        @(negedge clock);
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        modelReset();
    endtask

    // Monitor: every response is compared against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (resp_valid === 1'b1) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_resp", LINE_W'(resp_valid), LINE_W'(0));
                end else begin
                    e = expQ.pop_front();
                    checkOutput("resp_hit", LINE_W'(resp_hit), LINE_W'(e.hit));
                    checkOutput("resp_data", resp_data, e.data);
                end
            end
        end
    end

    // Memory responder: holds off ready, checks the request stays stable,
    // then returns the queued fill line after a short delay.
    initial begin
        logic [ADDR_W-1:0] a;
        logic [LINE_W-1:0] d;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        forever begin
            @(negedge clock);
            if (respMode != 2 && reset_n === 1'b1 && mem_req_valid === 1'b1) begin
                a = mem_req_addr;
                for (int i = 0; i < readyDelay; i++) begin
                    @(negedge clock);
                    checkOutput("hold_mem_req_valid", LINE_W'(mem_req_valid), LINE_W'(1));
                    checkOutput("hold_mem_req_addr", LINE_W'(mem_req_addr), LINE_W'(a));
                    checkOutput("hold_req_ready", LINE_W'(req_ready), LINE_W'(0));
                end
                mem_req_ready = 1'b1;
                @(posedge clock);
                #1 mem_req_ready = 1'b0;
                if (respMode == 1) begin
                    mAccepted = 1'b1;
                    wait (lateGo);
                    @(negedge clock);
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = genLine(0);
                    @(posedge clock);
                    #1 mem_rsp_valid = 1'b0;
                end else begin
                    if (memAddrQ.size() == 0) begin
                        checkOutput("unexpected_mem_req", LINE_W'(mem_req_valid), LINE_W'(0));
                        d = '0;
                    end else begin
                        checkOutput("mem_req_addr", LINE_W'(a), LINE_W'(memAddrQ.pop_front()));
                        d = memDataQ.pop_front();
                    end
                    repeat (rspDelay) @(negedge clock);
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = d;
                    @(posedge clock);
                    #1 mem_rsp_valid = 1'b0;
                end
            end
        end
    end

    initial begin
        logic [LINE_W-1:0] l;
        int                n;
        req_valid = 1'b0;
        req_addr  = '0;
        reset_n   = 1'b1;
        modelReset();
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("reset_req_ready", LINE_W'(req_ready), LINE_W'(1));
        checkOutput("reset_resp_valid", LINE_W'(resp_valid), LINE_W'(0));
        checkOutput("reset_resp_hit", LINE_W'(resp_hit), LINE_W'(0));
        checkOutput("reset_resp_data", resp_data, LINE_W'(0));
        checkOutput("reset_mem_req_valid", LINE_W'(mem_req_valid), LINE_W'(0));
        checkOutput("reset_mem_req_addr", LINE_W'(mem_req_addr), LINE_W'(0));
        checkOutput("reset_hit_cnt", LINE_W'(hit_cnt), LINE_W'(0));
        checkOutput("reset_miss_cnt", LINE_W'(miss_cnt), LINE_W'(0));
        reset_n = 1'b1;

        $display("[TB] quarter-compressed install, merge and hits");
        l = '0; l[15:0] = 16'h1234;
        applyStimulus(32'h0000_0000, l, 0);
        l = '0; l[15:0] = 16'h5678;
        applyStimulus(32'h0000_0040, l, 1);
        applyStimulus(32'h0000_0000, '0, 0);
        applyStimulus(32'h0000_0040, '0, 0);
        applyStimulus(32'h0000_0080, genLine(2), 2);
        @(negedge clock);
`ifdef YACC_STATS_EN
        checkOutput("stats_miss_cnt", LINE_W'(miss_cnt), LINE_W'(3));
        checkOutput("stats_hit_cnt", LINE_W'(hit_cnt), LINE_W'(2));
`else
        checkOutput("stats_miss_cnt", LINE_W'(miss_cnt), LINE_W'(0));
        checkOutput("stats_hit_cnt", LINE_W'(hit_cnt), LINE_W'(0));
`endif

        $display("[TB] set 0 overflow with uncompressed lines");
        resetDut();
        for (int t = 0; t < 9; t++) applyStimulus(ADDR_W'(t) << 11, genLine(0), $urandom_range(0, 2));
        applyStimulus(32'h0000_0000, genLine(0), 0);
        applyStimulus(32'h0000_4000, genLine(0), 0);

        $display("[TB] LRU refresh");
        resetDut();
        for (int t = 1; t <= 8; t++) applyStimulus(ADDR_W'(t) << 11, genLine(0), 0);
        applyStimulus(32'h0000_0800, genLine(0), 0);
        applyStimulus(32'h0000_4800, genLine(0), 0);
        applyStimulus(32'h0000_0800, genLine(0), 0);
        applyStimulus(32'h0000_1000, genLine(0), 0);

        $display("[TB] half-compressed pair");
        resetDut();
        applyStimulus(32'h0000_0080, genLine(1), 0);
        applyStimulus(32'h0000_00C0, genLine(1), 0);
        applyStimulus(32'h0000_0080, '0, 0);
        applyStimulus(32'h0000_00C0, '0, 0);

        $display("[TB] memory request held off");
        applyStimulus(32'h0001_2340, genLine(0), 5);

        $display("[TB] reset in MISS_REQ and MISS_WAIT");
        respMode = 2;
        @(negedge clock);
        req_addr  = 32'h0000_2A40;
        req_valid = 1'b1;
        @(posedge clock);
        #1 req_valid = 1'b0;
        n = 0;
        while (mem_req_valid !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (mem_req_valid !== 1'b1) timeoutFail("miss_req_wait");
        reset_n = 1'b0;
        #1;
        checkOutput("rst_missreq_mem_req_valid", LINE_W'(mem_req_valid), LINE_W'(0));
        checkOutput("rst_missreq_req_ready", LINE_W'(req_ready), LINE_W'(1));
        @(negedge clock);
        reset_n   = 1'b1;
        mAccepted = 1'b0;
        respMode  = 1;
        @(negedge clock);
        req_addr  = 32'h0000_2A40;
        req_valid = 1'b1;
        @(posedge clock);
        #1 req_valid = 1'b0;
        n = 0;
        while (!mAccepted && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!mAccepted) timeoutFail("mem_accept_wait");
        reset_n = 1'b0;
        #1;
        checkOutput("rst_misswait_mem_req_valid", LINE_W'(mem_req_valid), LINE_W'(0));
        checkOutput("rst_misswait_req_ready", LINE_W'(req_ready), LINE_W'(1));
        @(negedge clock);
        reset_n = 1'b1;
        modelReset();
        lateGo = 1'b1;
        repeat (6) begin
            @(negedge clock);
            checkOutput("late_rsp_resp_valid", LINE_W'(resp_valid), LINE_W'(0));
            checkOutput("late_rsp_mem_req_valid", LINE_W'(mem_req_valid), LINE_W'(0));
        end
        lateGo   = 1'b0;
        respMode = 0;
        applyStimulus(32'h0000_2A40, genLine(0), 0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 250; i++) begin
            logic [ADDR_W-1:0] a;
            a = (ADDR_W'($urandom_range(0, 11)) << 11) | (ADDR_W'($urandom_range(0, 1)) << 8) |
                (ADDR_W'($urandom_range(0, 3)) << 6) | ADDR_W'($urandom_range(0, 63));
            applyStimulus(a, genLine($urandom_range(0, 2)), $urandom_range(0, 3));
        end

        @(negedge clock);
        checkOutput("scoreboard_drained", LINE_W'(expQ.size()), LINE_W'(0));
        checkOutput("fill_queue_drained", LINE_W'(memDataQ.size()), LINE_W'(0));
`ifdef YACC_STATS_EN
        checkOutput("final_hit_cnt", LINE_W'(hit_cnt), LINE_W'(modelHits));
        checkOutput("final_miss_cnt", LINE_W'(miss_cnt), LINE_W'(modelMisses));
`else
        checkOutput("final_hit_cnt", LINE_W'(hit_cnt), LINE_W'(0));
        checkOutput("final_miss_cnt", LINE_W'(miss_cnt), LINE_W'(0));
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
